// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } apb_state_e;

  // Each slave owns one 4 KB region; the upper address bits select the slave.
  localparam int unsigned APB_REGION_BITS = 12;
  localparam logic [31:0] APB_DEFAULT_BASE = 32'h1000_0000;

endpackage

// File: rtl/apb_decoder.sv
// Address decoder: maps the 4 KB page number of a bus address onto a one-hot slave select.
module apb_decoder
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter logic [31:0] BASE_ADDR  = APB_DEFAULT_BASE
) (
  input  logic [31-APB_REGION_BITS:0] page_i,
  output logic                        hit_o,
  output logic [NUM_SLAVES-1:0]       sel_o
);

  localparam int unsigned PageW = 32 - APB_REGION_BITS;
  localparam logic [PageW-1:0] BasePage = BASE_ADDR[31:APB_REGION_BITS];

  logic [PageW-1:0] offset;

  always_comb begin
    offset = page_i - BasePage;
    // The lower-bound test keeps pages below the window from wrapping into a hit.
    hit_o  = (page_i >= BasePage) && (offset < PageW'(NUM_SLAVES));
    sel_o  = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (hit_o && (offset == PageW'(i))) begin
        sel_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// CPU bus to APB bridge: SETUP/ACCESS sequencing, read capture and a one-cycle ready pulse.
// Define APB_TIMEOUT_EN to bound ACCESS wait states to TIMEOUT_CYCLES (completes with err=1).
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter logic [31:0] BASE_ADDR      = APB_DEFAULT_BASE,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     transfer,
  input  logic                     write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata,
  output logic                     ready,
  output logic                     err,
  output logic [31:0]              PADDR,
  output logic [31:0]              PWDATA,
  output logic                     PWRITE,
  output logic                     PENABLE,
  output logic [NUM_SLAVES-1:0]    PSEL,
  input  logic [32*NUM_SLAVES-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]    PREADY
);

  if (NUM_SLAVES < 1 || NUM_SLAVES > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("apb_master: NUM_SLAVES must be 1..8 and TIMEOUT_CYCLES at least 1");
  end

  apb_state_e            state_q, state_d;
  logic [31:0]           paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic                  penable_q, penable_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  ready_q, ready_d;
  logic                  err_q, err_d;

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  logic                  dec_hit;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  hit;
  logic [31:0]           prdata_sel;
  logic                  pready_sel;
  logic                  done;

  apb_decoder #(
    .NUM_SLAVES(NUM_SLAVES),
    .BASE_ADDR (BASE_ADDR)
  ) u_decoder (
    .page_i(addr[31:APB_REGION_BITS]),
    .hit_o (dec_hit),
    .sel_o (dec_sel)
  );

  // The latched one-hot select doubles as the mux control and the hit flag.
  always_comb begin
    prdata_sel = '0;
    pready_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (psel_q[i]) begin
        prdata_sel = PRDATA[32*i +: 32];
        pready_sel = PREADY[i];
      end
    end
  end

  assign hit = |psel_q;

  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pwrite_d  = pwrite_q;
    penable_d = penable_q;
    psel_d    = psel_q;
    rdata_d   = rdata_q;
    ready_d   = 1'b0;
    err_d     = 1'b0;
    done      = 1'b0;
`ifdef APB_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        penable_d = 1'b0;
        psel_d    = '0;
        if (transfer) begin
          paddr_d  = addr;
          pwdata_d = wdata;
          pwrite_d = write;
          psel_d   = dec_hit ? dec_sel : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (!hit) begin
          done    = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else if (pready_sel) begin
          done = 1'b1;
          if (!pwrite_q) begin
            rdata_d = prdata_sel;
          end
        end else begin
`ifdef APB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            done    = 1'b1;
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end
        if (done) begin
          ready_d   = 1'b1;
          psel_d    = '0;
          penable_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = '0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      penable_q <= 1'b0;
      psel_q    <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pwrite_q  <= pwrite_d;
      penable_q <= penable_d;
      psel_q    <= psel_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      err_q     <= err_d;
`ifdef APB_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PENABLE = penable_q;
  assign PSEL    = psel_q;
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;

endmodule

// File: doc/apb_master.md
# apb_master

CPU-side to AMBA APB bridge sitting directly downstream of the multi-cycle datapath's bus port. Accepts one word-wide bus request (address, write data, direction), runs the APB SETUP/ACCESS sequence toward one of NUM_SLAVES memory-mapped peripherals, and returns read data plus a single-cycle completion strobe. The control unit holds the memory-access state until `ready` pulses.

## Interface
- NUM_SLAVES, 4, number of APB slaves (1–8); one PSEL bit each
- BASE_ADDR, 32'h1000_0000, base of the peripheral window; slave i occupies BASE_ADDR + i*0x1000, 4 KB each
- TIMEOUT_CYCLES, 16, ACCESS-phase wait limit (used only with APB_TIMEOUT_EN)
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- transfer  in  1  request strobe from control unit; sampled only in IDLE
- write  in  1  1 = write, 0 = read; sampled with transfer
- addr  in  32  byte address (busAddr); sampled with transfer
- wdata  in  32  write data (busWData); sampled with transfer
- rdata  out  32  read data (busRData); registered, valid when ready=1
- ready  out  1  one-cycle completion pulse
- err  out  1  qualifies ready; 1 = decode miss or timeout
- PADDR  out  32  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PENABLE  out  1  APB enable
- PSEL  out  NUM_SLAVES  one-hot slave select
- PRDATA  in  32*NUM_SLAVES  slave i read data at bits [32*i+31:32*i]
- PREADY  in  NUM_SLAVES  per-slave ready

## Operation
- FSM states IDLE, SETUP, ACCESS.
- IDLE: if transfer=1, latch addr/wdata/write into PADDR/PWDATA/PWRITE, latch decoded select, go to SETUP. Otherwise stay; PSEL=0, PENABLE=0.
- SETUP: PSEL[sel]=1, PENABLE=0; unconditionally go to ACCESS.
- ACCESS: PSEL[sel]=1, PENABLE=1. When PREADY[sel]=1: capture PRDATA[sel] into rdata (reads only; writes leave rdata unchanged), set ready=1 for one cycle, go to IDLE. Otherwise stay (wait state); PADDR/PWDATA/PWRITE/PSEL held stable.
- Decode: hit when addr[31:12] is in [BASE_ADDR[31:12], BASE_ADDR[31:12]+NUM_SLAVES-1]; sel = that difference. addr[1:0] ignored; word transfers only.
- Decode miss: PSEL stays all-zero through SETUP/ACCESS; ACCESS completes on its first cycle with ready=1, err=1, rdata=0.
- err=0 on every normal completion; err valid only while ready=1.
- transfer asserted outside IDLE is ignored; the control unit must not change addr/wdata until ready.
- Back-to-back: transfer high in the cycle where ready=1 (FSM already in IDLE) is accepted.
- Reset (reset=0 at an edge) overrides everything, including mid-transfer: state=IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rdata=0, ready=0, err=0, timeout counter=0.

## Timing
- Edge E0 samples transfer → SETUP during cycle E0–E1 → ACCESS from E1.
- Zero-wait slave (PREADY high in first ACCESS cycle): ready=1 in cycle after E2; minimum latency 3 cycles transfer-to-ready.
- Each PREADY-low ACCESS cycle adds one cycle.
- All outputs are registered; none combinational from inputs.

## Configuration
- APB_TIMEOUT_EN defined: counter cleared on SETUP→ACCESS, incremented each ACCESS cycle with PREADY[sel]=0; when it reaches TIMEOUT_CYCLES, transfer completes as ready=1, err=1, rdata=0, FSM→IDLE. PSEL/PENABLE drop as on normal completion.
- Not defined: no counter; ACCESS waits indefinitely for PREADY; TIMEOUT_CYCLES unused.

## Structure
- Package apb_pkg: state enum typedef (IDLE, SETUP, ACCESS), APB_REGION_BITS=12 constant, default BASE_ADDR constant.
- Sub-module apb_decoder: combinational addr → {hit, one-hot select}; parameterized by NUM_SLAVES and BASE_ADDR.
- Top holds FSM, request latches, read-data mux/capture, optional timeout counter.

## Test plan
- Write 0x1000_1004 ← 0xCAFE_0001, slave 1 PREADY tied high → PSEL=0010, PWRITE=1, SETUP one cycle, PENABLE next, ready with err=0 exactly 3 cycles after transfer.
- Read 0x1000_2008, slave 2 returns 0x1234_5678 after 2 wait states → PADDR/PSEL stable through waits, rdata=0x1234_5678, ready 5 cycles after transfer.
- Read 0x2000_0000 (unmapped) → PSEL never asserted, ready=1, err=1, rdata=0 at cycle 3.
- Two reads issued back-to-back (transfer high during ready) to slaves 0 and 3 → second SETUP immediately follows first completion, both rdata correct.
- Reset low during ACCESS with slave 0 stalled → next cycle PSEL=0, PENABLE=0, ready=0, state IDLE; fresh transfer then completes normally.
- APB_TIMEOUT_EN, slave 3 PREADY stuck low → ready=1, err=1, rdata=0 after exactly 16 ACCESS cycles; without the macro, no ready after 100 cycles.
